// File: rtl/router_pkg.sv
// Shared router types: port identifiers and the per-output allocation state.
package router_pkg;

  localparam int NUM_OF_PORTS_BITS = 3;

  typedef enum logic [NUM_OF_PORTS_BITS-1:0] {
    LOCAL     = 3'd0,
    EAST      = 3'd1,
    WEST      = 3'd2,
    NORTH     = 3'd3,
    SOUTH     = 3'd4,
    NONE_PORT = 3'd7
  } PORT_t;

  typedef enum logic {
    FREE = 1'b0,
    BUSY = 1'b1
  } ALLOC_STATE_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first active request at or after the pointer wins.
module rr_arbiter #(
  parameter int N     = 5,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant
);

  int   idx;
  logic found;

  // Scan from the pointer, wrapping modulo N, and grant the first requester.
  always_comb begin
    o_grant = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(i_ptr) + k) % N;
      if (!found && i_req[idx]) begin
        o_grant[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-output switch allocator: each output owns at most one input until that
// input signals its tail flit has been sent.
//
// state | meaning
// FREE  | output unallocated, may grant one counted request this cycle
// BUSY  | output owned by owner[o] until i_packet_done[owner[o]]
module switch_allocator
  import router_pkg::*;
#(
  parameter int NUM_OF_PORTS = 5,
  parameter int SEL_BITS     = $clog2(NUM_OF_PORTS)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_OF_PORTS-1:0]                i_switch_req,
  input  PORT_t [NUM_OF_PORTS-1:0]               i_req_port,
  input  logic [NUM_OF_PORTS-1:0]                i_packet_done,
  output logic [NUM_OF_PORTS-1:0]                o_switch_ack,
  output logic [NUM_OF_PORTS-1:0][SEL_BITS-1:0]  o_xbar_sel,
  output logic [NUM_OF_PORTS-1:0]                o_out_busy
);

  ALLOC_STATE_t              state_q  [NUM_OF_PORTS];
  logic [SEL_BITS-1:0]       owner_q  [NUM_OF_PORTS];
  logic [SEL_BITS-1:0]       rr_ptr_q [NUM_OF_PORTS];
  logic [NUM_OF_PORTS-1:0]   is_owner;
  logic [NUM_OF_PORTS-1:0]   req_mask [NUM_OF_PORTS];
  logic [NUM_OF_PORTS-1:0]   grant    [NUM_OF_PORTS];
  logic [SEL_BITS-1:0]       gnt_idx  [NUM_OF_PORTS];
  logic [SEL_BITS-1:0]       gnt_next [NUM_OF_PORTS];
  logic [NUM_OF_PORTS-1:0]   ack_next;

  // Inputs that already hold an output may not compete again.
  always_comb begin
    is_owner = '0;
    for (int o = 0; o < NUM_OF_PORTS; o++) begin
      if (state_q[o] == BUSY) is_owner[owner_q[o]] = 1'b1;
    end
  end

  // Counted requests per output; a BUSY output sees no requests so it cannot grant.
  always_comb begin
    for (int o = 0; o < NUM_OF_PORTS; o++) begin
      req_mask[o] = '0;
      for (int i = 0; i < NUM_OF_PORTS; i++) begin
        req_mask[o][i] = i_switch_req[i] && (i_req_port[i] != NONE_PORT) &&
                         (i_req_port[i] == NUM_OF_PORTS_BITS'(o)) &&
                         !is_owner[i] && (state_q[o] == FREE);
      end
    end
  end

  for (genvar g = 0; g < NUM_OF_PORTS; g++) begin : g_arb
    rr_arbiter #(
      .N     (NUM_OF_PORTS),
      .PTR_W (SEL_BITS)
    ) u_rr_arbiter (
      .i_req   (req_mask[g]),
      .i_ptr   (rr_ptr_q[g]),
      .o_grant (grant[g])
    );
  end

  // Encode each one-hot grant and the pointer value that follows the winner.
  always_comb begin
    ack_next = '0;
    for (int o = 0; o < NUM_OF_PORTS; o++) begin
      gnt_idx[o]  = '0;
      gnt_next[o] = '0;
      ack_next    = ack_next | grant[o];
      for (int i = 0; i < NUM_OF_PORTS; i++) begin
        if (grant[o][i]) begin
          gnt_idx[o]  = SEL_BITS'(i);
          gnt_next[o] = (i == NUM_OF_PORTS - 1) ? '0 : SEL_BITS'(i + 1);
        end
      end
    end
  end

  // Per-output FREE/BUSY FSM with owner, round-robin pointer and ack pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_switch_ack <= '0;
      for (int o = 0; o < NUM_OF_PORTS; o++) begin
        state_q[o]  <= FREE;
        owner_q[o]  <= '0;
        rr_ptr_q[o] <= '0;
      end
    end else begin
      o_switch_ack <= ack_next;
      for (int o = 0; o < NUM_OF_PORTS; o++) begin
        case (state_q[o])
          FREE: begin
            if (|grant[o]) begin
              state_q[o]  <= BUSY;
              owner_q[o]  <= gnt_idx[o];
              rr_ptr_q[o] <= gnt_next[o];
            end
          end
          BUSY: begin
            if (i_packet_done[owner_q[o]]) begin
              state_q[o] <= FREE;
              owner_q[o] <= '0;
            end
          end
          default: state_q[o] <= FREE;
        endcase
      end
    end
  end

  // Busy flag and crossbar select follow the FSM; select reads 0 while FREE.
  always_comb begin
    for (int o = 0; o < NUM_OF_PORTS; o++) begin
      o_out_busy[o] = (state_q[o] == BUSY);
      o_xbar_sel[o] = (state_q[o] == BUSY) ? owner_q[o] : '0;
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed scoreboard bench for switch_allocator.
module tb_switch_allocator;
  import router_pkg::*;

  logic             clk;
  logic             reset;
  logic [4:0]       req;
  PORT_t [4:0]      req_port;
  logic [4:0]       done;
  logic [4:0]       ack;
  logic [4:0][2:0]  xbar;
  logic [4:0]       busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    logic [4:0]  ack;
    logic [4:0]  busy;
    logic [14:0] xbar;
  } exp_t;

  exp_t sb_q[$];

  switch_allocator dut (
    .clk           (clk),
    .reset         (reset),
    .i_switch_req  (req),
    .i_req_port    (req_port),
    .i_packet_done (done),
    .o_switch_ack  (ack),
    .o_xbar_sel    (xbar),
    .o_out_busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [14:0] sel(input int o, input int v);
    logic [14:0] r;
    r = '0;
    r[o*3 +: 3] = 3'(v);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [4:0] b, input logic [14:0] x);
    exp_t e;
    e.cyc  = cyc + 1;
    e.ack  = a;
    e.busy = b;
    e.xbar = x;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every ack must match the next expected grant in cycle and content.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
          e = sb_q.pop_front();
          checks   = checks + 1;
          failures = failures + 1;
          $display("FAIL missing_ack actual=none expected=%b at cycle %0d", e.ack, e.cyc);
        end
        if (ack != 5'b0) begin
          if (sb_q.size() == 0) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL unexpected_ack actual=%b expected=none (cycle %0d)", ack, cyc);
          end else begin
            e = sb_q.pop_front();
            chk("ack_cycle", 32'(cyc), 32'(e.cyc));
            chk("ack_vec", 32'(ack), 32'(e.ack));
            chk("busy_at_ack", 32'(busy), 32'(e.busy));
            chk("xbar_at_ack", 32'(xbar), 32'(e.xbar));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    req   = '0;
    done  = '0;
    for (int i = 0; i < 5; i++) req_port[i] = NONE_PORT;
    #3;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_xbar", 32'(xbar), 0);
    step();
    step();
    reset = 1'b0;
    step();

    // Single request: input 2 -> EAST
    req[2] = 1'b1; req_port[2] = EAST;
    push(5'b00100, 5'b00010, sel(1, 2));
    step();
    req[2] = 1'b0; req_port[2] = NONE_PORT;
    step();
    done[2] = 1'b1;
    step();
    done[2] = 1'b0;
    chk("east_released", 32'(busy), 0);

    // Contention on NORTH from inputs 0, 2, 4
    req[0] = 1'b1; req[2] = 1'b1; req[4] = 1'b1;
    req_port[0] = NORTH; req_port[2] = NORTH; req_port[4] = NORTH;
    push(5'b00001, 5'b01000, 15'b0);
    step();
    req[0] = 1'b0;
    step(); step();
    done[0] = 1'b1;
    step();
    done[0] = 1'b0;
    chk("north_free_after0", 32'(busy), 0);
    push(5'b00100, 5'b01000, sel(3, 2));
    step();
    req[2] = 1'b0;
    step(); step();
    done[2] = 1'b1;
    step();
    done[2] = 1'b0;
    push(5'b10000, 5'b01000, sel(3, 4));
    step();
    req[4] = 1'b0;
    step(); step();
    done[4] = 1'b1;
    step();
    done[4] = 1'b0;
    chk("north_free_after4", 32'(busy), 0);
    // Pointer wrapped to 0: input 0 beats input 4
    req[0] = 1'b1; req[4] = 1'b1;
    push(5'b00001, 5'b01000, 15'b0);
    step();
    req[0] = 1'b0; req[4] = 1'b0;
    step();
    done[0] = 1'b1;
    step();
    done[0] = 1'b0;
    for (int i = 0; i < 5; i++) req_port[i] = NONE_PORT;

    // Same-cycle release on WEST
    req[1] = 1'b1; req_port[1] = WEST;
    push(5'b00010, 5'b00100, sel(2, 1));
    step();
    req[1] = 1'b0;
    step();
    done[1] = 1'b1; req[3] = 1'b1; req_port[3] = WEST;
    step();
    done[1] = 1'b0;
    chk("west_free_gap", 32'(busy), 0);
    push(5'b01000, 5'b00100, sel(2, 3));
    step();
    req[3] = 1'b0;
    step();
    done[3] = 1'b1;
    step();
    done[3] = 1'b0;
    chk("west_released", 32'(busy), 0);

    // Parallel allocation: 0 -> SOUTH, 1 -> LOCAL
    req[0] = 1'b1; req_port[0] = SOUTH;
    req[1] = 1'b1; req_port[1] = LOCAL;
    push(5'b00011, 5'b10001, sel(0, 1));
    step();
    req[0] = 1'b0; req[1] = 1'b0;
    step();

    // Non-owner done is ignored
    done[3] = 1'b1;
    step();
    done[3] = 1'b0;
    chk("nonowner_busy", 32'(busy), 32'(5'b10001));
    chk("nonowner_xbar", 32'(xbar), 32'(sel(0, 1)));

    // NONE_PORT request yields nothing
    req[2] = 1'b1; req_port[2] = NONE_PORT;
    step(); step();
    chk("none_port_busy", 32'(busy), 32'(5'b10001));

    // Third output busy; the owner keeps requesting and must not be re-acked
    req_port[2] = EAST;
    push(5'b00100, 5'b10011, sel(0, 1) | sel(1, 2));
    step();
    step(); step();
    chk("three_busy", 32'(busy), 32'(5'b10011));

    // Asynchronous reset mid-cycle drops all ownership
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_xbar", 32'(xbar), 0);
    chk("async_rst_ack", 32'(ack), 0);
    req = '0;
    for (int i = 0; i < 5; i++) req_port[i] = NONE_PORT;
    step(); step();
    reset = 1'b0;

    // Pointers restart at 0: input 0 beats input 4 on NORTH
    req[0] = 1'b1; req[4] = 1'b1;
    req_port[0] = NORTH; req_port[4] = NORTH;
    push(5'b00001, 5'b01000, 15'b0);
    step();
    req[0] = 1'b0; req[4] = 1'b0;
    step();
    done[0] = 1'b1;
    step();
    done[0] = 1'b0;
    chk("post_rst_released", 32'(busy), 0);

    step(); step();
    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 Parameter NUM_OF_PORTS, default 5, number of router input and output ports: LOCAL=0, EAST=1, WEST=2, NORTH=3, SOUTH=4.
REQ-002 Parameter SEL_BITS, default $clog2(NUM_OF_PORTS) (3), width of a port index.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 i_switch_req  input  NUM_OF_PORTS  per-input request, held high while the input unit is in ROUTING.
REQ-007 i_req_port  input  NUM_OF_PORTS x PORT_t  per-input requested output port; NONE_PORT means no valid target.
REQ-008 i_packet_done  input  NUM_OF_PORTS  per-input tail-flit-sent pulse.
REQ-009 o_switch_ack  output  NUM_OF_PORTS  per-input one-cycle grant pulse.
REQ-010 o_xbar_sel  output  NUM_OF_PORTS x SEL_BITS  per-output index of the owning input.
REQ-011 o_out_busy  output  NUM_OF_PORTS  per-output flag: allocated to an input.

Function
REQ-012 Each output SHALL have a two-state FSM: FREE and BUSY.
- FREE->BUSY on grant.
- BUSY->FREE when i_packet_done[owner] is high.
REQ-013 A request from input i SHALL count for output o only when i_switch_req[i]=1, i_req_port[i]=o, i_req_port[i]!=NONE_PORT, and input i is not already an owner.
REQ-014 A FREE output with one or more counted requests SHALL grant exactly one input per cycle.
- Round-robin search starts at rr_ptr[o] and wraps modulo NUM_OF_PORTS.
REQ-015 On a grant to input i, the block SHALL do all of the following at the next clock edge:
- register owner[o]=i;
- set rr_ptr[o]=(i+1) mod NUM_OF_PORTS, wrapping 4->0;
- pulse o_switch_ack[i] high for exactly one cycle.
REQ-016 Grant latency SHALL be one cycle: a request sampled at edge N produces an ack that is high during cycle N+1 and o_out_busy[o]=1 from that edge onward.
REQ-017 A BUSY output SHALL NOT grant; losing or blocked inputs receive no ack and keep requesting without penalty.
REQ-018 If i_packet_done[owner] is high in the same cycle that new requests target the output, the output SHALL release in that cycle and grant no earlier than the following cycle (no same-cycle bypass).
REQ-019 i_packet_done from a non-owner SHALL be ignored.
REQ-020 o_xbar_sel[o] SHALL equal owner[o] while BUSY and 0 while FREE.
- Downstream logic qualifies it with o_out_busy.
REQ-021 Outputs SHALL allocate independently; distinct outputs may grant to distinct inputs in the same cycle.
REQ-022 An input SHALL receive at most one ack per packet, because it requests a single port.
REQ-023 A request that drops before it is granted SHALL be withdrawn with no state change.

Reset
REQ-024 While reset=1, all of the following SHALL hold asynchronously:
- every output FSM=FREE;
- owner=0 and rr_ptr=0;
- o_switch_ack=0, o_out_busy=0, o_xbar_sel=0.
REQ-025 Reset asserted mid-packet SHALL drop all ownership; after deassertion, allocation SHALL start from the reset state at the first clock edge.

Structure
REQ-026 The following SHALL live in router_pkg:
- PORT_t;
- NUM_OF_PORTS_BITS;
- the ALLOC_STATE_t enum (FREE, BUSY).
REQ-027 A sub-module rr_arbiter SHALL provide a parameterised round-robin arbiter (request vector and pointer in, one-hot grant out).
- The allocator SHALL instantiate one rr_arbiter per output port.

Verification
REQ-028 Single request: input 2 requests EAST at cycle 0 -> ack[2] high in cycle 1 only, o_out_busy[1]=1, o_xbar_sel[1]=2.
REQ-029 Contention: inputs 0, 2 and 4 request NORTH simultaneously, each packet done after 3 cycles -> grants in order 0, 2, 4, one ack each; rr_ptr[3] wraps to 0 after the grant to 4.
REQ-030 Same-cycle release: owner 1 of WEST pulses done while input 3 requests WEST -> WEST is FREE for one cycle, ack[3] comes one cycle later, never in the same cycle as done.
REQ-031 Parallel allocation: input 0 requests SOUTH and input 1 requests LOCAL in the same cycle -> both acked in the same cycle, o_xbar_sel[4]=0, o_xbar_sel[0]=1.
REQ-032 Ignored events:
- a NONE_PORT request -> no ack;
- done from a non-owner -> output stays BUSY;
- reset asserted while 3 outputs are BUSY -> all outputs FREE immediately, no ack.
